// File: rtl/pc_seq_pkg.sv
// Shared constants and state encoding for the instruction-fetch PC sequencer.
package pc_seq_pkg;

    localparam int unsigned PcWidth          = 32;
    localparam int unsigned DefaultImemDepth = 32;

    typedef logic [1:0] pc_state_t;

    localparam pc_state_t StBoot  = 2'd0;
    localparam pc_state_t StRun   = 2'd1;
    localparam pc_state_t StFlush = 2'd2;
    localparam pc_state_t StHalt  = 2'd3;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: branch redirect, stall hold or increment with range check.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = DefaultImemDepth,
    parameter bit          WRAP_EN    = 1'b0
) (
    input  logic [PcWidth-1:0] pc,
    input  pc_state_t          state,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PcWidth-1:0] branch_target,
    output logic [PcWidth-1:0] next_pc,
    output logic               out_of_range,
    output logic               redirect
);

    // One extra bit so an increment from 2^32-1 is caught by the same compare.
    logic [PcWidth:0]   pc_plus;
    logic [PcWidth:0]   depth;
    logic               target_oor;
    logic [PcWidth-1:0] inc_pc;
    logic               inc_oor;

    assign pc_plus    = {1'b0, pc} + {{PcWidth{1'b0}}, 1'b1};
    assign depth      = {1'b0, IMEM_DEPTH[PcWidth-1:0]};
    assign target_oor = {1'b0, branch_target} >= depth;

    always_comb begin
        inc_pc  = pc_plus[PcWidth-1:0];
        inc_oor = 1'b0;
        if (pc_plus >= depth) begin
            if (WRAP_EN) begin
                inc_pc = '0;
            end else begin
                inc_pc  = pc;
                inc_oor = 1'b1;
            end
        end
    end

    always_comb begin
        next_pc      = pc;
        out_of_range = 1'b0;
        redirect     = 1'b0;
        case (state)
            StRun: begin
                if (branch_taken) begin
                    if (target_oor) begin
                        out_of_range = 1'b1;
                    end else begin
                        next_pc  = branch_target;
                        redirect = 1'b1;
                    end
                end else if (!stall) begin
                    next_pc      = inc_pc;
                    out_of_range = inc_oor;
                end
            end
            // Wrong-path slots cannot raise stall or branch, so only the increment applies.
            StFlush: begin
                next_pc      = inc_pc;
                out_of_range = inc_oor;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter generator: owns the architectural PC, flush window and fault state.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned IMEM_DEPTH  = DefaultImemDepth,
    parameter int unsigned FLUSH_SLOTS = 2,
    parameter bit          WRAP_EN     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [PcWidth-1:0] branch_target_i,
    output logic [PcWidth-1:0] PCout,
    output logic               fetch_valid_o,
    output logic               flush_o,
    output logic               pc_fault_o
);

    localparam logic [PcWidth-1:0] ResetPc   = RESET_PC;
    localparam logic [2:0]         FlushInit = 3'(FLUSH_SLOTS);

    pc_state_t          state_q, state_d;
    logic [PcWidth-1:0] pc_q, pc_d;
    logic [2:0]         flush_cnt_q, flush_cnt_d;
    logic               out_of_range;
    logic               redirect;

    pc_next_sel #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .WRAP_EN    (WRAP_EN)
    ) u_next_sel (
        .pc            (pc_q),
        .state         (state_q),
        .stall         (stall_i),
        .branch_taken  (branch_taken_i),
        .branch_target (branch_target_i),
        .next_pc       (pc_d),
        .out_of_range  (out_of_range),
        .redirect      (redirect)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                if (out_of_range) begin
                    state_d = StHalt;
                end else if (redirect) begin
                    state_d     = StFlush;
                    flush_cnt_d = FlushInit;
                end
            end
            StFlush: begin
                flush_cnt_d = flush_cnt_q - 3'd1;
                if (out_of_range) begin
                    state_d     = StHalt;
                    flush_cnt_d = '0;
                end else if (flush_cnt_q <= 3'd1) begin
                    state_d     = StRun;
                    flush_cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StBoot;
            pc_q        <= ResetPc;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign PCout         = pc_q;
    assign fetch_valid_o = (state_q == StRun) || (state_q == StFlush);
    assign flush_o       = (state_q == StFlush);
    assign pc_fault_o    = (state_q == StHalt);

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven scoreboard bench for pc_sequencer, covering a faulting and a wrapping instance.
module tb_pc_sequencer;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        v;
        logic        fl;
        logic        ft;
        bit          wrap;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = '0;

    logic [31:0] pc_f, pc_w;
    logic        v_f, fl_f, ft_f, v_w, fl_w, ft_w;

    int n_cmp = 0;
    int n_bad = 0;
    int step_no = 0;

    vec_t tbl[$];
    vec_t sb_q[$];

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC    (0),
        .IMEM_DEPTH  (32),
        .FLUSH_SLOTS (2),
        .WRAP_EN     (1'b0)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall),
        .branch_taken_i  (br),
        .branch_target_i (tgt),
        .PCout           (pc_f),
        .fetch_valid_o   (v_f),
        .flush_o         (fl_f),
        .pc_fault_o      (ft_f)
    );

    pc_sequencer #(
        .RESET_PC    (0),
        .IMEM_DEPTH  (32),
        .FLUSH_SLOTS (2),
        .WRAP_EN     (1'b1)
    ) dut_wrap (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall),
        .branch_taken_i  (br),
        .branch_target_i (tgt),
        .PCout           (pc_w),
        .fetch_valid_o   (v_w),
        .flush_o         (fl_w),
        .pc_fault_o      (ft_w)
    );

    function automatic vec_t mk(input logic r, input logic s, input logic b, input int t,
                                input int p, input logic v, input logic fl, input logic ft,
                                input bit w);
        vec_t x;
        x.rst = r; x.stall = s; x.br = b; x.tgt = t;
        x.pc = p; x.v = v; x.fl = fl; x.ft = ft; x.wrap = w;
        return x;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step_no, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard step %0d: got empty queue expected one entry", step_no);
            return;
        end
        e = sb_q.pop_front();
        if (e.wrap) begin
            cmp("wrap_pc", pc_w, e.pc);
            cmp("wrap_valid", {31'd0, v_w}, {31'd0, e.v});
            cmp("wrap_flush", {31'd0, fl_w}, {31'd0, e.fl});
            cmp("wrap_fault", {31'd0, ft_w}, {31'd0, e.ft});
        end else begin
            cmp("pc", pc_f, e.pc);
            cmp("valid", {31'd0, v_f}, {31'd0, e.v});
            cmp("flush", {31'd0, fl_f}, {31'd0, e.fl});
            cmp("fault", {31'd0, ft_f}, {31'd0, e.ft});
        end
    endtask

    task automatic apply(input vec_t x);
        @(negedge clk);
        rst   = x.rst;
        stall = x.stall;
        br    = x.br;
        tgt   = x.tgt;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        step_no++;
        check_out();
    endtask

    initial begin
        // Fields: rst stall br tgt | pc valid flush fault | wrap-instance
        tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  2, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  3, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  4, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  5, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  5, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  5, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  5, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  6, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 12, 12, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 3,  13, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  14, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  15, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 31, 31, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  31, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 5,  31, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0,  31, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 40, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 29, 29, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  30, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  31, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  31, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  31, 0, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Reset in the middle of a flush window.
        apply(mk(1, 0, 0, 0,  0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0,  0, 1, 0, 0, 0));
        apply(mk(0, 0, 1, 10, 10, 1, 1, 0, 0));
        apply(mk(1, 0, 0, 0,  0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0,  0, 1, 0, 0, 0));
        apply(mk(0, 0, 0, 0,  1, 1, 0, 0, 0));

        // Wrapping instance: overflow at the end of a flush window and from RUN.
        apply(mk(1, 0, 0, 0,  0, 0, 0, 0, 1));
        apply(mk(0, 0, 0, 0,  0, 1, 0, 0, 1));
        apply(mk(0, 0, 1, 30, 30, 1, 1, 0, 1));
        apply(mk(0, 0, 0, 0,  31, 1, 1, 0, 1));
        apply(mk(0, 0, 0, 0,  0, 1, 0, 0, 1));
        apply(mk(0, 0, 0, 0,  1, 1, 0, 0, 1));
        apply(mk(0, 0, 1, 28, 28, 1, 1, 0, 1));
        apply(mk(0, 0, 0, 0,  29, 1, 1, 0, 1));
        apply(mk(0, 0, 0, 0,  30, 1, 0, 0, 1));
        apply(mk(0, 0, 0, 0,  31, 1, 0, 0, 1));
        apply(mk(0, 0, 0, 0,  0, 1, 0, 0, 1));
        apply(mk(0, 0, 1, 32, 0, 0, 0, 1, 1));
        apply(mk(0, 0, 0, 0,  0, 0, 0, 1, 1));

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter generator for the instruction-fetch stage: it owns the architectural PC and drives the fetch unit's `PCin` every cycle. Each cycle it either advances the word-addressed PC by one, holds it on a hazard stall, or redirects it to a resolved branch target. After a redirect it squashes the wrong-path slots already in flight, and it halts with a fault flag when the PC leaves instruction memory.

## Interface
Parameters:
- `RESET_PC`, 0: word address of the first fetch after reset.
- `IMEM_DEPTH`, 32: number of instruction-memory words; the legal PC range is 0..IMEM_DEPTH-1.
- `FLUSH_SLOTS`, 2: number of cycles `flush_o` stays asserted after a taken branch; legal range 1..7.
- `WRAP_EN`, 0: 1 means sequential overflow wraps to 0; 0 means overflow faults.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `stall_i`, input, 1: hazard-unit request to hold the PC.
- `branch_taken_i`, input, 1: a branch has resolved taken this cycle.
- `branch_target_i`, input, 32: word address of the branch target; sampled only when `branch_taken_i` is 1.
- `PCout`, output, 32: fetch address; connects to the fetch unit's `PCin`.
- `fetch_valid_o`, output, 1: `PCout` is a real fetch request.
- `flush_o`, output, 1: the instruction now leaving fetch is wrong-path; IF/ID must squash it.
- `pc_fault_o`, output, 1: sticky flag; the PC went out of range.

## Operation
- States: BOOT, RUN, FLUSH, HALT. A 3-bit `flush_cnt` is also held.
- Reset values, applied on any cycle `rst` is high, including mid-operation:
  - state = BOOT, `PCout` = RESET_PC, `flush_cnt` = 0.
  - `fetch_valid_o` = 0, `flush_o` = 0, `pc_fault_o` = 0.
- BOOT: always moves to RUN on the next cycle. The PC is held, so the first valid fetch is at RESET_PC.
- RUN, with priority branch > stall > increment:
  - Branch: if `branch_target_i` < IMEM_DEPTH, then PC = target, `flush_cnt` = FLUSH_SLOTS, and go to FLUSH. Otherwise go to HALT and set the fault flag.
  - Stall: hold the PC and stay in RUN.
  - Increment: PC = PC+1.
    - If PC+1 equals IMEM_DEPTH and WRAP_EN=1, the PC becomes 0.
    - If PC+1 equals IMEM_DEPTH and WRAP_EN=0, go to HALT with the fault flag set, and hold the PC at the last legal word.
- FLUSH:
  - The PC increments every cycle with the same overflow rule as RUN.
  - `stall_i` and `branch_taken_i` are ignored, since wrong-path slots cannot raise them.
  - `flush_cnt` decrements every cycle; when it reaches 0 the state returns to RUN.
- HALT: the PC holds. Only `rst` exits this state.
- Outputs are Moore:
  - `fetch_valid_o` = 1 in RUN and FLUSH.
  - `flush_o` = 1 exactly when in FLUSH.
  - `pc_fault_o` = 1 in HALT.
- Arithmetic: the PC register is a full 32 bits. The range compare is unsigned against IMEM_DEPTH. An increment that would reach 2^32 is out of range by the same rule.

## Timing
- Branch latency: with `branch_taken_i` high at edge t, `PCout` = target after edge t; instruction[target] leaves fetch one cycle later (fetch registers its read).
- `flush_o` is high for exactly FLUSH_SLOTS consecutive cycles starting after edge t.
- Stall: `PCout` changes one edge after `stall_i` deasserts; a stall lasting N cycles holds the PC for N cycles.
- A branch and a stall in the same RUN cycle: the branch wins and the stall is dropped.
- Reset during FLUSH or HALT: after that edge, all outputs take their reset values.
- No combinational path from any input to any output.

## Structure
- `pc_seq_pkg` holds:
  - the state enum (BOOT, RUN, FLUSH, HALT);
  - the 32-bit PC width constant;
  - the default IMEM_DEPTH.
- Sub-module `pc_next_sel` is combinational. It takes the current PC, the state, the inputs and the parameters, and returns `next_pc` and an `out_of_range` flag. `pc_sequencer` keeps the state register, the PC register and `flush_cnt`.

## Test plan
- Reset with RESET_PC=0: one cycle of BOOT with `fetch_valid_o`=0, then `PCout` reads 0,1,2,3 on successive cycles.
- Stall held for 3 cycles at PC=5: `PCout` stays 5 for 3 cycles, then reads 6.
- Branch to target 12 while PC=6, with `stall_i` also high: `PCout` reads 12, 13, 14 while `flush_o` is high for 2 cycles, then `flush_o` returns to 0 in RUN.
- WRAP_EN=0 with the PC at 31: `pc_fault_o` goes to 1, `fetch_valid_o` to 0, and `PCout` holds 31 until `rst`. With WRAP_EN=1 the sequence is 31 then 0.
- Branch target 40 with IMEM_DEPTH=32: the block enters HALT with `pc_fault_o`=1 and the PC unchanged.
- `rst` asserted in the middle of FLUSH: next cycle `PCout`=RESET_PC, `flush_o`=0 and the state is BOOT.
